id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipelined CPU. It sits directly upstream of the EX-stage ALU operand-B select: it produces ealuimm, eqb and eSignExtend for that select, along with all other EX-stage controls.
- It also holds the decode-stage operand-forwarding muxes and the load-use interlock. It drives wpcir, which stalls the PC and IF/ID, and inserts a bubble into EX.
- It keeps a saturating stall-cycle counter for debug.

Parameters:
- DATA_W, 32, datapath width.
- RA_W, 5, register-address width.
- CNT_W, 16, stall counter width.

Ports:
- clock in 1: rising-edge clock.
- resetn in 1: asynchronous active-low reset.
- dvalid in 1: IF/ID holds a real instruction.
- flush in 1: kill the decode instruction (taken branch/jump redirect).
- dwreg, dm2reg, dwmem, daluimm, dshift, djal in 1 each: decode controls.
- daluc in 4: ALU op.
- drs, drt, drn in RA_W: source and destination register numbers.
- duse_rs, duse_rt in 1: instruction reads rs / rt.
- dqa, dqb in DATA_W: register-file read data.
- dSignExtend in DATA_W: extended immediate.
- dpc4 in DATA_W: PC+4.
- ealu in DATA_W: current EX ALU result (forward source).
- mwreg, mm2reg in 1: MEM-stage controls.
- mrn in RA_W: MEM-stage destination register.
- malu, mmo in DATA_W: MEM-stage ALU result / memory read data.
- wpcir out 1: PC and IF/ID write enable; 0 means stall.
- ewreg, em2reg, ewmem, ealuimm, eshift, ejal, evalid out 1: registered controls.
- ealuc out 4: registered ALU op.
- ern out RA_W: registered destination register.
- eqa, eqb, eSignExtend, epc4 out DATA_W: registered operands.
- stall_cnt out CNT_W: stall cycles since reset.

Behaviour:
- Reset (resetn=0, asynchronous): every registered output is 0, including evalid and stall_cnt. wpcir is therefore 1.
- Latency: one cycle from d* inputs to e* outputs.
- Forward A (combinational, priority order):
  - ewreg & ~em2reg & ern!=0 & ern==drs -> ealu.
  - else mwreg & mrn!=0 & mrn==drs -> (mm2reg ? mmo : malu).
  - else dqa.
- Forward B: identical to forward A, using drt and dqb.
- A register-0 destination is never forwarded.
- stall = dvalid & ~flush & evalid & ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
- wpcir = ~stall (combinational).
- Bubble condition: stall | flush | ~dvalid. On the next edge all e* outputs load 0, including data fields, and evalid=0.
- Otherwise, on the next edge:
  - all e* load their d* counterparts;
  - eqa and eqb load the forwarded values;
  - evalid=1.
- After a one-cycle stall the bubble clears the EX hazard, so stall drops and the held instruction issues. A load-use hazard therefore costs exactly one bubble.
- flush has priority over stall. flush=1 forces stall=0, so wpcir=1 and the redirect proceeds.
- stall_cnt increments by 1 on every edge where stall=1 and saturates at all-ones; it does not wrap.
- Reset asserted mid-stall clears evalid, so stall deasserts immediately.
- Bubbles must never write registers or memory: ewreg=0, ewmem=0, ern=0.

Test Plan:
- Reset: hold resetn=0 while d* toggles -> all e* = 0, stall_cnt=0, wpcir=1; after release the first valid instruction appears on e* one edge later.
- Plain issue: dvalid=1, daluimm=1, dSignExtend=0xFFFFFFF0, dqb=0x5 -> next edge ealuimm=1, eSignExtend=0xFFFFFFF0, eqb=0x5, evalid=1.
- EX forward: ern=3, ewreg=1, em2reg=0, ealu=0x1234, drs=3, duse_rs=1, dqa=0x9 -> eqa=0x1234. Same case with ern=0 -> eqa=0x9.
- MEM forward priority: ern=4 (ewreg=1, em2reg=0, ealu=0xA), mrn=4 (mwreg=1, mm2reg=1, mmo=0xB), drt=4 -> eqb=0xA. Remove the EX match -> eqb=0xB.
- Load-use: ewreg=em2reg=1, ern=5, drt=5, duse_rt=1 -> wpcir=0 for one cycle, bubble issued (evalid=0, ewreg=0), stall_cnt 0->1; the held instruction then issues and gets eqb from mmo.
- Flush vs stall: the load-use condition of the previous case plus flush=1 -> wpcir=1, bubble issued, stall_cnt unchanged.
- Saturation: force 0xFFFF+2 stall cycles -> stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode-stage operand forwarding, the load-use
// interlock that drives wpcir, and a saturating debug stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              dvalid,
  input  logic              flush,
  input  logic              dwreg,
  input  logic              dm2reg,
  input  logic              dwmem,
  input  logic              daluimm,
  input  logic              dshift,
  input  logic              djal,
  input  logic [3:0]        daluc,
  input  logic [RA_W-1:0]   drs,
  input  logic [RA_W-1:0]   drt,
  input  logic [RA_W-1:0]   drn,
  input  logic              duse_rs,
  input  logic              duse_rt,
  input  logic [DATA_W-1:0] dqa,
  input  logic [DATA_W-1:0] dqb,
  input  logic [DATA_W-1:0] dSignExtend,
  input  logic [DATA_W-1:0] dpc4,
  input  logic [DATA_W-1:0] ealu,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic [RA_W-1:0]   mrn,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mmo,
  output logic              wpcir,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic              eshift,
  output logic              ejal,
  output logic              evalid,
  output logic [3:0]        ealuc,
  output logic [RA_W-1:0]   ern,
  output logic [DATA_W-1:0] eqa,
  output logic [DATA_W-1:0] eqb,
  output logic [DATA_W-1:0] eSignExtend,
  output logic [DATA_W-1:0] epc4,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ewreg_q, ewreg_d;
  logic              em2reg_q, em2reg_d;
  logic              ewmem_q, ewmem_d;
  logic              ealuimm_q, ealuimm_d;
  logic              eshift_q, eshift_d;
  logic              ejal_q, ejal_d;
  logic              evalid_q, evalid_d;
  logic [3:0]        ealuc_q, ealuc_d;
  logic [RA_W-1:0]   ern_q, ern_d;
  logic [DATA_W-1:0] eqa_q, eqa_d;
  logic [DATA_W-1:0] eqb_q, eqb_d;
  logic [DATA_W-1:0] esext_q, esext_d;
  logic [DATA_W-1:0] epc4_q, epc4_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              ex_fwd_ok;
  logic              ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic [DATA_W-1:0] mem_data, fwd_a, fwd_b;
  logic              load_in_ex, stall, bubble;

  // Only a non-load EX result exists yet; a load in EX is handled by the stall.
  assign ex_fwd_ok = ewreg_q & ~em2reg_q & (ern_q != '0);
  assign ex_hit_a  = ex_fwd_ok & (ern_q == drs);
  assign ex_hit_b  = ex_fwd_ok & (ern_q == drt);
  assign mem_hit_a = mwreg & (mrn != '0) & (mrn == drs);
  assign mem_hit_b = mwreg & (mrn != '0) & (mrn == drt);
  assign mem_data  = mm2reg ? mmo : malu;

  always_comb begin
    fwd_a = dqa;
    if (ex_hit_a)
      fwd_a = ealu;
    else if (mem_hit_a)
      fwd_a = mem_data;
  end

  always_comb begin
    fwd_b = dqb;
    if (ex_hit_b)
      fwd_b = ealu;
    else if (mem_hit_b)
      fwd_b = mem_data;
  end

  assign load_in_ex = evalid_q & ewreg_q & em2reg_q & (ern_q != '0);
  assign stall  = dvalid & ~flush & load_in_ex &
                  ((duse_rs & (ern_q == drs)) | (duse_rt & (ern_q == drt)));
  assign bubble = stall | flush | ~dvalid;
  assign wpcir  = ~stall;

  always_comb begin
    ewreg_d   = 1'b0;
    em2reg_d  = 1'b0;
    ewmem_d   = 1'b0;
    ealuimm_d = 1'b0;
    eshift_d  = 1'b0;
    ejal_d    = 1'b0;
    evalid_d  = 1'b0;
    ealuc_d   = '0;
    ern_d     = '0;
    eqa_d     = '0;
    eqb_d     = '0;
    esext_d   = '0;
    epc4_d    = '0;
    if (!bubble) begin
      ewreg_d   = dwreg;
      em2reg_d  = dm2reg;
      ewmem_d   = dwmem;
      ealuimm_d = daluimm;
      eshift_d  = dshift;
      ejal_d    = djal;
      evalid_d  = 1'b1;
      ealuc_d   = daluc;
      ern_d     = drn;
      eqa_d     = fwd_a;
      eqb_d     = fwd_b;
      esext_d   = dSignExtend;
      epc4_d    = dpc4;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ewreg_q     <= 1'b0;
      em2reg_q    <= 1'b0;
      ewmem_q     <= 1'b0;
      ealuimm_q   <= 1'b0;
      eshift_q    <= 1'b0;
      ejal_q      <= 1'b0;
      evalid_q    <= 1'b0;
      ealuc_q     <= '0;
      ern_q       <= '0;
      eqa_q       <= '0;
      eqb_q       <= '0;
      esext_q     <= '0;
      epc4_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ewreg_q     <= ewreg_d;
      em2reg_q    <= em2reg_d;
      ewmem_q     <= ewmem_d;
      ealuimm_q   <= ealuimm_d;
      eshift_q    <= eshift_d;
      ejal_q      <= ejal_d;
      evalid_q    <= evalid_d;
      ealuc_q     <= ealuc_d;
      ern_q       <= ern_d;
      eqa_q       <= eqa_d;
      eqb_q       <= eqb_d;
      esext_q     <= esext_d;
      epc4_q      <= epc4_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ewreg       = ewreg_q;
  assign em2reg      = em2reg_q;
  assign ewmem       = ewmem_q;
  assign ealuimm     = ealuimm_q;
  assign eshift      = eshift_q;
  assign ejal        = ejal_q;
  assign evalid      = evalid_q;
  assign ealuc       = ealuc_q;
  assign ern         = ern_q;
  assign eqa         = eqa_q;
  assign eqb         = eqb_q;
  assign eSignExtend = esext_q;
  assign epc4        = epc4_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed
// expectations, a monitor pops them as each cycle's outputs appear.
module tb_id_ex_stage;

  typedef struct packed {
    logic        resetn, dvalid, flush, dwreg, dm2reg, dwmem, daluimm, dshift, djal;
    logic [3:0]  daluc;
    logic [4:0]  drs, drt, drn;
    logic        duse_rs, duse_rt;
    logic [31:0] dqa, dqb, dse, dpc4, ealu;
    logic        mwreg, mm2reg;
    logic [4:0]  mrn;
    logic [31:0] malu, mmo;
  } vec_t;

  typedef struct packed {
    logic        wpcir, evalid, ewreg, em2reg, ewmem, ealuimm, eshift, ejal;
    logic [3:0]  ealuc;
    logic [4:0]  ern;
    logic [31:0] eqa, eqb, ese, epc4;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  logic        clock, resetn, dvalid, flush;
  logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [3:0]  daluc;
  logic [4:0]  drs, drt, drn, mrn;
  logic        duse_rs, duse_rt, mwreg, mm2reg;
  logic [31:0] dqa, dqb, dse, dpc4, ealu, malu, mmo;

  logic        wpcir, ewreg, em2reg, ewmem, ealuimm, eshift, ejal, evalid;
  logic [3:0]  ealuc;
  logic [4:0]  ern;
  logic [31:0] eqa, eqb, ese, epc4;
  logic [15:0] stall_cnt;

  logic        s_wpcir, s_ewreg, s_em2reg, s_ewmem, s_ealuimm, s_eshift, s_ejal, s_evalid;
  logic [3:0]  s_ealuc;
  logic [4:0]  s_ern;
  logic [31:0] s_eqa, s_eqb, s_ese, s_epc4;
  logic [3:0]  s_stall_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  id_ex_stage dut (
    .clock(clock), .resetn(resetn), .dvalid(dvalid), .flush(flush),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .dshift(dshift), .djal(djal), .daluc(daluc), .drs(drs), .drt(drt), .drn(drn),
    .duse_rs(duse_rs), .duse_rt(duse_rt), .dqa(dqa), .dqb(dqb),
    .dSignExtend(dse), .dpc4(dpc4), .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg),
    .mrn(mrn), .malu(malu), .mmo(mmo), .wpcir(wpcir), .ewreg(ewreg),
    .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm), .eshift(eshift),
    .ejal(ejal), .evalid(evalid), .ealuc(ealuc), .ern(ern), .eqa(eqa), .eqb(eqb),
    .eSignExtend(ese), .epc4(epc4), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  id_ex_stage #(.CNT_W(4)) dut_sat (
    .clock(clock), .resetn(resetn), .dvalid(dvalid), .flush(flush),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .dshift(dshift), .djal(djal), .daluc(daluc), .drs(drs), .drt(drt), .drn(drn),
    .duse_rs(duse_rs), .duse_rt(duse_rt), .dqa(dqa), .dqb(dqb),
    .dSignExtend(dse), .dpc4(dpc4), .ealu(ealu), .mwreg(mwreg), .mm2reg(mm2reg),
    .mrn(mrn), .malu(malu), .mmo(mmo), .wpcir(s_wpcir), .ewreg(s_ewreg),
    .em2reg(s_em2reg), .ewmem(s_ewmem), .ealuimm(s_ealuimm), .eshift(s_eshift),
    .ejal(s_ejal), .evalid(s_evalid), .ealuc(s_ealuc), .ern(s_ern), .eqa(s_eqa),
    .eqb(s_eqb), .eSignExtend(s_ese), .epc4(s_epc4), .stall_cnt(s_stall_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '0;
    v.resetn = 1'b1;
    v.dpc4 = 32'h0000_0100;
    return v;
  endfunction

  // Drive one decode cycle; xw/xv/xa/xb are the hand-computed wpcir, evalid, eqa, eqb.
  task automatic applyStimulus(input vec_t v, input logic xw, input logic xv,
                               input logic [31:0] xa, input logic [31:0] xb);
    exp_t e;
    @(posedge clock);
    #2;
    resetn = v.resetn; dvalid = v.dvalid; flush = v.flush;
    dwreg = v.dwreg; dm2reg = v.dm2reg; dwmem = v.dwmem; daluimm = v.daluimm;
    dshift = v.dshift; djal = v.djal; daluc = v.daluc;
    drs = v.drs; drt = v.drt; drn = v.drn; duse_rs = v.duse_rs; duse_rt = v.duse_rt;
    dqa = v.dqa; dqb = v.dqb; dse = v.dse; dpc4 = v.dpc4; ealu = v.ealu;
    mwreg = v.mwreg; mm2reg = v.mm2reg; mrn = v.mrn; malu = v.malu; mmo = v.mmo;
    e = '0;
    e.wpcir = xw;
    if (xv && v.resetn) begin
      e.evalid = 1'b1; e.ewreg = v.dwreg; e.em2reg = v.dm2reg; e.ewmem = v.dwmem;
      e.ealuimm = v.daluimm; e.eshift = v.dshift; e.ejal = v.djal; e.ealuc = v.daluc;
      e.ern = v.drn; e.eqa = xa; e.eqb = xb; e.ese = v.dse; e.epc4 = v.dpc4;
    end
    if (!v.resetn)
      exp_cnt = 0;
    else if (!xw)
      exp_cnt++;
    e.cnt   = (exp_cnt > 65535) ? 16'hFFFF : 16'(exp_cnt);
    e.cnt_s = (exp_cnt > 15) ? 4'hF : 4'(exp_cnt);
    sb.push_back(e);
  endtask

  // Monitor: wpcir is checked mid-cycle, the registered bundle just after the edge.
  initial begin
    exp_t r;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        checkOutput("wpcir", 32'(wpcir), 32'(r.wpcir));
        @(posedge clock);
        #1;
        checkOutput("evalid", 32'(evalid), 32'(r.evalid));
        checkOutput("ewreg", 32'(ewreg), 32'(r.ewreg));
        checkOutput("em2reg", 32'(em2reg), 32'(r.em2reg));
        checkOutput("ewmem", 32'(ewmem), 32'(r.ewmem));
        checkOutput("ealuimm", 32'(ealuimm), 32'(r.ealuimm));
        checkOutput("eshift", 32'(eshift), 32'(r.eshift));
        checkOutput("ejal", 32'(ejal), 32'(r.ejal));
        checkOutput("ealuc", 32'(ealuc), 32'(r.ealuc));
        checkOutput("ern", 32'(ern), 32'(r.ern));
        checkOutput("eqa", eqa, r.eqa);
        checkOutput("eqb", eqb, r.eqb);
        checkOutput("eSignExtend", ese, r.ese);
        checkOutput("epc4", epc4, r.epc4);
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(r.cnt));
        checkOutput("stall_cnt_sat", 32'(s_stall_cnt), 32'(r.cnt_s));
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    resetn = 1'b0;
    {dvalid, flush, dwreg, dm2reg, dwmem, daluimm, dshift, djal} = '0;
    daluc = '0; drs = '0; drt = '0; drn = '0; mrn = '0;
    duse_rs = 1'b0; duse_rt = 1'b0; mwreg = 1'b0; mm2reg = 1'b0;
    dqa = '0; dqb = '0; dse = '0; dpc4 = '0; ealu = '0; malu = '0; mmo = '0;

    // Reset held while decode inputs toggle
    v = idle_vec(); v.resetn = 0; v.dvalid = 1; v.dwreg = 1; v.drn = 5'd3; v.dqa = 32'hAA;
    applyStimulus(v, 1, 0, 0, 0);
    v.dwmem = 1; v.dqb = 32'h55; v.daluc = 4'h7;
    applyStimulus(v, 1, 0, 0, 0);

    // First instruction after release
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.drn = 5'd7; v.dqa = 32'h11; v.dqb = 32'h22;
    v.daluc = 4'h5; v.dpc4 = 32'h104; v.drs = 5'd1; v.duse_rs = 1;
    applyStimulus(v, 1, 1, 32'h11, 32'h22);

    // Plain issue with immediate
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.daluimm = 1; v.dse = 32'hFFFF_FFF0;
    v.dqa = 32'h1; v.dqb = 32'h5; v.drs = 5'd2; v.drn = 5'd8; v.dshift = 1; v.djal = 1;
    applyStimulus(v, 1, 1, 32'h1, 32'h5);

    // Put r3 producer into EX
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.drn = 5'd3; v.dqa = 32'h33; v.dqb = 32'h44;
    applyStimulus(v, 1, 1, 32'h33, 32'h44);

    // EX forward to A; leaves a r0 writer in EX
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.drn = 5'd0; v.drs = 5'd3; v.duse_rs = 1;
    v.dqa = 32'h9; v.ealu = 32'h1234; v.drt = 5'd1; v.dqb = 32'h55; v.daluc = 4'hC;
    applyStimulus(v, 1, 1, 32'h1234, 32'h55);

    // r0 destinations in EX and MEM are not forwarded
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.drn = 5'd4; v.drs = 5'd0; v.duse_rs = 1;
    v.dqa = 32'h9; v.ealu = 32'h1234; v.mwreg = 1; v.mrn = 5'd0; v.malu = 32'hDEAD;
    v.dqb = 32'h66;
    applyStimulus(v, 1, 1, 32'h9, 32'h66);

    // EX beats MEM for the same register
    v = idle_vec(); v.dvalid = 1; v.drn = 5'd4; v.drt = 5'd4; v.duse_rt = 1; v.ealu = 32'hA;
    v.mwreg = 1; v.mrn = 5'd4; v.mm2reg = 1; v.mmo = 32'hB; v.dqb = 32'h77;
    v.drs = 5'd9; v.dqa = 32'h99;
    applyStimulus(v, 1, 1, 32'h99, 32'hA);

    // EX no longer writes: MEM load data wins; this instruction is a load to r5
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.dm2reg = 1; v.drn = 5'd5;
    v.drs = 5'd4; v.drt = 5'd4; v.dqa = 32'h1; v.dqb = 32'h2; v.ealu = 32'hA;
    v.mwreg = 1; v.mrn = 5'd4; v.mm2reg = 1; v.mmo = 32'hB; v.malu = 32'hC;
    applyStimulus(v, 1, 1, 32'hB, 32'hB);

    // Load-use on rt: one stall cycle, bubble into EX
    v = idle_vec(); v.dvalid = 1; v.dwmem = 1; v.drt = 5'd5; v.duse_rt = 1; v.dqb = 32'h1;
    applyStimulus(v, 0, 0, 0, 0);

    // Held instruction issues with the loaded value from MEM
    v.mwreg = 1; v.mm2reg = 1; v.mrn = 5'd5; v.mmo = 32'h5A5A; v.malu = 32'h40;
    applyStimulus(v, 1, 1, 32'h0, 32'h5A5A);

    // Flush overrides the load-use stall
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.dm2reg = 1; v.drn = 5'd5;
    v.dqa = 32'h10; v.dqb = 32'h20;
    applyStimulus(v, 1, 1, 32'h10, 32'h20);
    v = idle_vec(); v.dvalid = 1; v.flush = 1; v.dwreg = 1; v.drn = 5'd6; v.drt = 5'd5;
    v.duse_rt = 1;
    applyStimulus(v, 1, 0, 0, 0);

    // Reset asserted while a load-use hazard is presented
    v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.dm2reg = 1; v.drn = 5'd5;
    v.dqa = 32'h30; v.dqb = 32'h40;
    applyStimulus(v, 1, 1, 32'h30, 32'h40);
    v = idle_vec(); v.resetn = 0; v.dvalid = 1; v.drt = 5'd5; v.duse_rt = 1;
    applyStimulus(v, 1, 0, 0, 0);

    // Invalid decode slot is a bubble even with live controls
    v = idle_vec(); v.dwreg = 1; v.dwmem = 1; v.drn = 5'd9; v.dqa = 32'h123; v.dqb = 32'h456;
    applyStimulus(v, 1, 0, 0, 0);

    // Back-to-back dependent loads: stall every other cycle, counters saturate
    for (int i = 0; i < 40; i++) begin
      v = idle_vec(); v.dvalid = 1; v.dwreg = 1; v.dm2reg = 1; v.drn = 5'd5;
      v.drt = 5'd5; v.duse_rt = 1; v.dqb = 32'h100 + 32'(i);
      if (i % 2 == 0)
        applyStimulus(v, 1, 1, 32'h0, 32'h100 + 32'(i));
      else
        applyStimulus(v, 0, 0, 0, 0);
    end

    v = idle_vec();
    applyStimulus(v, 1, 0, 0, 0);

    repeat (3) @(posedge clock);
    #3;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
